// File: rtl/uart_rx_hex.sv
// 8N1 UART receiver that decodes ASCII hex characters into a nibble.
// Valid digits are presented on dout one cycle ahead of a single-cycle come strobe.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | line idle, waiting for a falling edge on the synchronised rxd
// START | timing to mid start bit, rejects glitches
// DATA  | sampling 8 data bits LSB first, one per DIV cycles
// STOP  | timing to mid stop bit, checks framing and decodes the byte
// EMIT  | digit loaded on dout, come fires on the following cycle
module uart_rx_hex #(
  parameter int DIV = 5208,
  parameter int CW  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [3:0] dout,
  output logic       come,
  output logic [7:0] rx_byte,
  output logic       bad_char,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, EMIT} state_t;

  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          rxd_m;
  logic          rxd_s;
  logic          rxd_d;
  logic          start_det;
  logic          hex_ok;
  logic [3:0]    hex_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_d <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      rxd_d <= rxd_s;
    end
  end

  assign start_det = rxd_d & ~rxd_s;

  // Letters A-F / a-f have low nibble 1..6, so adding 9 yields 10..15.
  always_comb begin
    hex_ok  = 1'b1;
    hex_val = 4'h0;
    if (shreg >= 8'h30 && shreg <= 8'h39)
      hex_val = shreg[3:0];
    else if ((shreg >= 8'h41 && shreg <= 8'h46) || (shreg >= 8'h61 && shreg <= 8'h66))
      hex_val = shreg[3:0] + 4'd9;
    else
      hex_ok = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      dout      <= 4'hF;
      come      <= 1'b0;
      rx_byte   <= 8'h00;
      bad_char  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      come      <= 1'b0;
      bad_char  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start_det) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rxd_s) begin
              bit_idx <= 3'd0;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rxd_s, shreg[7:1]};
            if (bit_idx == 3'd7)
              state <= STOP;
            else
              bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rxd_s) begin
              rx_byte <= shreg;
              if (hex_ok) begin
                dout  <= hex_val;
                state <= EMIT;
              end else begin
                bad_char <= 1'b1;
                state    <= IDLE;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        EMIT: begin
          come  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_hex.sv
// Bench for uart_rx_hex: directed scenarios plus random frames, checked against
// an event-level reference model of the receiver's outcomes.
module tb_uart_rx_hex;
  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic [3:0] dout;
  logic       come;
  logic [7:0] rx_byte;
  logic       bad_char;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx_hex #(.DIV(DIV), .CW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .dout      (dout),
    .come      (come),
    .rx_byte   (rx_byte),
    .bad_char  (bad_char),
    .frame_err (frame_err),
    .busy      (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // kind: 0 = come, 1 = bad_char, 2 = frame_err
  typedef struct {
    int         kind;
    logic [7:0] val;
    logic [3:0] d;
    logic [3:0] dprev;
    int         cyc;
  } ev_t;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  logic [3:0] dout_prev = 4'hF;
  logic       come_prev = 1'b0;
  int         come_wide = 0;

  always @(negedge clk) begin
    ev_t e;
    e.val = rx_byte; e.d = dout; e.dprev = dout_prev; e.cyc = cyc;
    if (come)      begin e.kind = 0; obs_q.push_back(e); end
    if (bad_char)  begin e.kind = 1; obs_q.push_back(e); end
    if (frame_err) begin e.kind = 2; obs_q.push_back(e); end
    if (come && come_prev) come_wide++;
    come_prev = come;
    dout_prev = dout;
  end

  // Reference model: what a frame should produce, given the last good digit and byte.
  logic [3:0] m_digit = 4'hF;
  logic [7:0] m_rx    = 8'h00;

  function automatic int hex_of(input logic [7:0] b);
    int v;
    v = int'(b);
    if (v >= 48 && v <= 57)  return v - 48;
    if (v >= 65 && v <= 70)  return v - 65 + 10;
    if (v >= 97 && v <= 102) return v - 97 + 10;
    return -1;
  endfunction

  task automatic model_frame(input logic [7:0] b, input logic stop);
    ev_t e;
    int  h;
    e.cyc = 0;
    if (!stop) begin
      e.kind = 2; e.val = m_rx; e.d = m_digit; e.dprev = m_digit;
    end else begin
      m_rx = b;
      h = hex_of(b);
      if (h < 0) begin
        e.kind = 1; e.val = b; e.d = m_digit; e.dprev = m_digit;
      end else begin
        m_digit = h[3:0];
        e.kind = 0; e.val = b; e.d = m_digit; e.dprev = m_digit;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic v, input int n);
    rxd = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int last_fall = 0;

  task automatic send_frame(input logic [7:0] b, input logic stop, input int gap);
    model_frame(b, stop);
    last_fall = cyc;
    drive(1'b0, DIV);
    for (int i = 0; i < 8; i++) drive(b[i], DIV);
    drive(stop, DIV);
    if (gap > 0) drive(1'b1, gap);
  endtask

  task automatic check_events(input string tag);
    ev_t o;
    ev_t x;
    repeat (3 * DIV) @(posedge clk);
    #1;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      o = obs_q.pop_front();
      x = exp_q.pop_front();
      chk({tag, "_kind"},  o.kind,  x.kind);
      chk({tag, "_byte"},  o.val,   x.val);
      chk({tag, "_dout"},  o.d,     x.d);
      chk({tag, "_setup"}, o.dprev, x.dprev);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int         lat;
    logic       seen;
    int         last_busy;
    logic [7:0] b;
    logic       stop;
    int         gap;
    string      hexs;

    hexs = "0123456789ABCDEFabcdef";
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", dout, 4'hF);
    chk("rst_come", come, 1'b0);
    chk("rst_rx_byte", rx_byte, 8'h00);
    chk("rst_bad_char", bad_char, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b1;
    drive(1'b1, 2 * DIV);

    // single digit, with latency window from the falling edge
    send_frame(8'h37, 1'b1, DIV);
    repeat (DIV) @(posedge clk);
    #1;
    lat = (obs_q.size() > 0) ? obs_q[0].cyc - last_fall : -1;
    chk("t1_latency_in_window", (lat >= 153 && lat <= 159), 1'b1);
    check_events("t1");
    chk("t1_rx_byte", rx_byte, 8'h37);

    // back-to-back frames
    send_frame(8'h62, 1'b1, 0);
    send_frame(8'h46, 1'b1, DIV);
    check_events("t2");

    // non-hex character
    send_frame(8'h47, 1'b1, DIV);
    check_events("t3");
    chk("t3_dout_held", dout, m_digit);
    chk("t3_rx_byte", rx_byte, 8'h47);

    // framing error, line held low, then recovery
    send_frame(8'h35, 1'b0, 0);
    drive(1'b0, 3 * DIV);
    drive(1'b1, 2 * DIV);
    send_frame(8'h32, 1'b1, DIV);
    check_events("t4");
    chk("t4_dout", dout, 4'h2);

    // short glitch on the line
    seen = 1'b0;
    last_busy = -1;
    drive(1'b0, 4);
    rxd = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) begin
        seen = 1'b1;
        last_busy = i;
      end
    end
    chk("t5_busy_seen", seen, 1'b1);
    chk("t5_busy_cleared", (last_busy <= 9), 1'b1);
    check_events("t5");

    // randomized frames
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 1) == 0) b = hexs[$urandom_range(0, 21)];
      else b = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      if (stop) gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 40);
      else gap = DIV + $urandom_range(0, 20);
      send_frame(b, stop, gap);
    end
    check_events("rnd");

    // reset in the middle of bit 4
    send_frame(8'h33, 1'b1, DIV);
    check_events("t6_pre");
    b = 8'h5A;
    drive(1'b0, DIV);
    for (int i = 0; i < 4; i++) drive(b[i], DIV);
    drive(b[4], DIV / 2);
    rst = 1'b0;
    #1;
    chk("t6_dout", dout, 4'hF);
    chk("t6_busy", busy, 1'b0);
    chk("t6_come", come, 1'b0);
    chk("t6_rx_byte", rx_byte, 8'h00);
    rxd = 1'b1;
    m_digit = 4'hF;
    m_rx = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b1, 2 * DIV);
    chk("t6_busy_after", busy, 1'b0);
    check_events("t6_abort");
    send_frame(8'h61, 1'b1, DIV);
    check_events("t6_post");
    chk("t6_dout_after", dout, 4'hA);

    chk("come_width", come_wide, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
